// File: rtl/mux_rr_pipe_pkg.sv
// Shared definitions for the registered channel multiplexer family:
// mode encodings and the channel-index width helper.
package tpu_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width for n channels; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_rr_pipe_rr_pick.sv
// Round-robin picker: finds the first requesting channel after ptr,
// wrapping modulo NCH, with ptr itself examined last.
module rr_pick
  import tpu_mux_pkg::*;
#(
  parameter  int NCH  = 4,
  localparam int SELW = sel_width(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  grant_onehot,
  output logic [SELW-1:0] grant_idx,
  output logic            any
);

  // Walk ptr+1 .. ptr+NCH; the subtraction keeps the index modulo NCH for any NCH.
  always_comb begin
    int              cand;
    logic [SELW-1:0] cand_idx;
    cand         = 0;
    cand_idx     = '0;
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NCH) cand = cand - NCH;
      cand_idx = cand[SELW-1:0];
      if (!any && req[cand_idx]) begin
        any                    = 1'b1;
        grant_idx              = cand_idx;
        grant_onehot[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_pipe.sv
// N-channel valid/ready multiplexer with one output register. The grant
// comes from sel_in (fixed mode) or a round-robin search (rr mode); both
// feed the same one-hot data select.
module mux_rr_pipe
  import tpu_mux_pkg::*;
#(
  parameter  int WIDTH = 17,
  parameter  int NCH   = 4,
  localparam int SELW  = sel_width(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel_in,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] chan_data [NCH];
  logic [NCH-1:0]   fixed_onehot;
  logic             fixed_any;
  logic [NCH-1:0]   rr_onehot;
  logic [SELW-1:0]  rr_idx;
  logic             rr_any;

  logic [NCH-1:0]   grant_onehot;
  logic [SELW-1:0]  grant_idx;
  logic             grant_any;
  logic [WIDTH-1:0] sel_data;
  logic             load;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  // An out-of-range sel_in matches no channel and therefore grants nothing.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    assign chan_data[gi]    = in_data[gi*WIDTH +: WIDTH];
    assign fixed_onehot[gi] = in_valid[gi] & (sel_in == SELW'(gi));
  end
  assign fixed_any = |fixed_onehot;

  rr_pick #(.NCH(NCH)) u_pick (
    .req          (in_valid),
    .ptr          (ptr_q),
    .grant_onehot (rr_onehot),
    .grant_idx    (rr_idx),
    .any          (rr_any)
  );

  // Pick the grant source for the current mode.
  always_comb begin
    grant_onehot = fixed_onehot;
    grant_idx    = sel_in;
    grant_any    = fixed_any;
    if (mode == MODE_RR) begin
      grant_onehot = rr_onehot;
      grant_idx    = rr_idx;
      grant_any    = rr_any;
    end
  end

  // One-hot AND-OR data select shared by both modes.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_onehot[i]) sel_data = sel_data | chan_data[i];
    end
  end

  assign load     = ~out_valid_q | out_ready;
  assign in_ready = rst ? '0 : (grant_onehot & {NCH{load}});

  // Next state: load a granted beat, empty on a grant-less load, else hold.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = grant_any;
      if (grant_any) begin
        out_data_d = sel_data;
        out_chan_d = grant_idx;
        if (mode == MODE_RR) ptr_d = grant_idx;
      end
    end
  end

  // Output register and last-grant pointer; ptr resets so the first search starts at channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SELW'(NCH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_pipe.sv
// Bench for mux_rr_pipe: directed scenarios plus randomized traffic against
// a queue-free behavioural model (grant rule + one output slot).
module tb_mux_rr_pipe;
  import tpu_mux_pkg::*;

  localparam int W = 17;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- NCH=4 instance ----------------
  logic           rst, mode, out_ready, out_valid;
  logic [1:0]     sel_in, out_chan;
  logic [N-1:0]   in_valid, in_ready;
  logic [W-1:0]   din [N];
  logic [N*W-1:0] in_data;
  logic [W-1:0]   out_data;
  assign in_data = {din[3], din[2], din[1], din[0]};

  mux_rr_pipe #(.WIDTH(W), .NCH(N)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel_in(sel_in),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // ---------------- NCH=3 instance ----------------
  logic         b_rst, b_mode, b_out_ready, b_out_valid;
  logic [1:0]   b_sel, b_out_chan;
  logic [2:0]   b_valid, b_in_ready;
  logic [W-1:0] b_din [3];
  logic [3*W-1:0] b_data;
  logic [W-1:0] b_out_data;
  assign b_data = {b_din[2], b_din[1], b_din[0]};

  mux_rr_pipe #(.WIDTH(W), .NCH(3)) dut3 (
    .clk(clk), .rst(b_rst), .mode(b_mode), .sel_in(b_sel),
    .in_data(b_data), .in_valid(b_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_chan(b_out_chan), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  // ---------------- reference model (NCH=4) ----------------
  int       m_ptr;
  logic     m_valid;
  logic [W-1:0] m_data;
  int       m_chan;

  function automatic int m_grant();
    if (mode == MODE_FIXED) begin
      if (int'(sel_in) < N && in_valid[sel_in]) return int'(sel_in);
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = m_grant();
    if (!rst && (!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_ptr = N - 1; m_valid = 1'b0; m_data = '0; m_chan = 0;
  endtask

  // Advance the model by one edge using the pre-edge inputs, then clock the DUT.
  task automatic tick();
    int g;
    g = m_grant();
    if (!m_valid || out_ready) begin
      if (g >= 0) begin
        m_valid = 1'b1; m_data = din[g]; m_chan = g;
        if (mode == MODE_RR) m_ptr = g;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; mode = MODE_RR; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < N; i++) din[i] = W'(17'h100 + i);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b want=0000", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== 17'h0 || out_chan !== 2'd0) begin errors++; $display("FAIL reset_regs got=%h/%0d want=0/0", out_data, out_chan); end
    rst = 1'b0; model_reset(); #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got=%b want=0001", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_chan !== 2'd0) begin errors++; $display("FAIL reset_first_beat got=%b/%0d want=1/0", out_valid, out_chan); end
  endtask

  task automatic test_rr_full();
    int seq [5] = '{0, 1, 2, 3, 0};
    do_reset();
    mode = MODE_RR; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < N; i++) din[i] = W'(17'h100 + i);
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (in_ready !== m_ready()) begin errors++; $display("FAIL rr_full_ready[%0d] got=%b want=%b", k, in_ready, m_ready()); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_chan !== 2'(seq[k])) begin errors++; $display("FAIL rr_full_chan[%0d] got=%b/%0d want=1/%0d", k, out_valid, out_chan, seq[k]); end
      checks++; if (out_data !== W'(17'h100 + seq[k])) begin errors++; $display("FAIL rr_full_data[%0d] got=%h want=%h", k, out_data, 17'h100 + seq[k]); end
    end
  endtask

  task automatic test_rr_sparse();
    int seq [4] = '{1, 3, 1, 3};
    do_reset();
    mode = MODE_RR; in_valid = 4'b1010; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (in_ready !== 4'(1 << seq[k])) begin errors++; $display("FAIL rr_sparse_ready[%0d] got=%b want=%b", k, in_ready, 4'(1 << seq[k])); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_chan !== 2'(seq[k])) begin errors++; $display("FAIL rr_sparse_chan[%0d] got=%b/%0d want=1/%0d", k, out_valid, out_chan, seq[k]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = MODE_RR; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 1; i < N; i++) din[i] = W'(17'h100 + i);
    din[0] = 17'h1ABCD;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 17'h1ABCD) begin errors++; $display("FAIL bp_load got=%b/%h want=1/1abcd", out_valid, out_data); end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      din[0] = W'($urandom);
      #1;
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got=%b want=0000", k, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 17'h1ABCD || out_chan !== 2'd0) begin errors++; $display("FAIL bp_hold[%0d] got=%b/%h/%0d want=1/1abcd/0", k, out_valid, out_data, out_chan); end
    end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got=%b want=0010", in_ready); end
    tick();
    checks++; if (out_chan !== 2'd1 || out_data !== 17'h101) begin errors++; $display("FAIL bp_release_beat got=%0d/%h want=1/101", out_chan, out_data); end
  endtask

  task automatic test_fixed();
    do_reset();
    mode = MODE_FIXED; sel_in = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
    din[2] = 17'h00042; #1;
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL fixed_ready got=%b want=0100", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 17'h00042 || out_chan !== 2'd2) begin errors++; $display("FAIL fixed_beat got=%b/%h/%0d want=1/00042/2", out_valid, out_data, out_chan); end
    in_valid = 4'b0001; out_ready = 1'b0; #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL fixed_stall_ready got=%b want=0000", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fixed_stall_hold got=%b want=1", out_valid); end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL fixed_nogrant_ready got=%b want=0000", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fixed_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 300; k++) begin
      mode      = 1'($urandom_range(0, 1));
      sel_in    = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) din[i] = W'($urandom);
      #1;
      checks++; if (in_ready !== m_ready()) begin errors++; $display("FAIL rand_ready[%0d] got=%b want=%b", k, in_ready, m_ready()); end
      tick();
      checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rand_valid[%0d] got=%b want=%b", k, out_valid, m_valid); end
      if (m_valid) begin
        checks++; if (out_data !== m_data || out_chan !== 2'(m_chan)) begin errors++; $display("FAIL rand_beat[%0d] got=%h/%0d want=%h/%0d", k, out_data, out_chan, m_data, m_chan); end
      end
    end
  endtask

  task automatic test_nch3();
    int seq [4] = '{0, 1, 2, 0};
    b_rst = 1'b1; b_mode = MODE_FIXED; b_sel = 2'd3; b_valid = 3'b111; b_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) b_din[i] = W'(17'h10 + i);
    @(posedge clk); #1;
    b_rst = 1'b0; #1;
    checks++; if (b_in_ready !== 3'b000) begin errors++; $display("FAIL n3_sel3_ready got=%b want=000", b_in_ready); end
    @(posedge clk); #1;
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL n3_sel3_valid got=%b want=0", b_out_valid); end
    b_mode = MODE_RR; #1;
    checks++; if (b_in_ready !== 3'b001) begin errors++; $display("FAIL n3_rr_first got=%b want=001", b_in_ready); end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++; if (b_out_valid !== 1'b1 || b_out_chan !== 2'(seq[k]) || b_out_data !== W'(17'h10 + seq[k])) begin
        errors++; $display("FAIL n3_wrap[%0d] got=%b/%0d/%h want=1/%0d/%h", k, b_out_valid, b_out_chan, b_out_data, seq[k], 17'h10 + seq[k]);
      end
    end
    #2 b_rst = 1'b1;
    #1;
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL n3_async_valid got=%b want=0", b_out_valid); end
    checks++; if (b_in_ready !== 3'b000) begin errors++; $display("FAIL n3_async_ready got=%b want=000", b_in_ready); end
    #1 b_rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = MODE_FIXED; sel_in = '0; in_valid = '0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) din[i] = '0;
    b_rst = 1'b1; b_mode = MODE_FIXED; b_sel = '0; b_valid = '0; b_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) b_din[i] = '0;
    model_reset();
    #1;
    test_reset();
    test_rr_full();
    test_rr_sparse();
    test_backpressure();
    test_fixed();
    test_random();
    test_nch3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
